control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcoded control unit that sits directly upstream of the 8-bit CPU datapath.
- Consumes OPCODE, CF and ZF from the datapath and drives every datapath control strobe, one T-state per clock.
- Implements a fixed fetch / execute step counter, a halt state and a run / single-step front end.
- Also provides a one-cycle datapath clear after reset.

Parameters:
- NSTEPS, 5: T-states per instruction (T0..NSTEPS-1); legal range 3..8.
- EARLY_END, 1: if 1, return to T0 after an instruction's last active step; if 0, always run all NSTEPS steps.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- RUN  input  1  1 = free-run; 0 = single-step mode.
- STEP  input  1  single-step request, sampled when RUN=0; one advance per cycle it is high.
- OPCODE  input  4  instruction register high nibble.
- CF, ZF  input  1  registered ALU flags.
- CLR  output  1  datapath clear.
- CE  output  1  PC increment.
- SU  output  1  ALU subtract.
- AIn, BIn, OIn, IIn, Jn, FIn, MIn, RI  output  1 each  load strobes (A, B, OUT, IR, PC jump, flags, MAR, RAM write).
- DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn  output  1 each  bus-driver selects (debug, A, B, IR low, PC, ALU, RAM, input).
- TSTATE  output  3  current step index.
- HALTED  output  1  1 while in HALT.

Behaviour:
- Polarity: all strobes and selects are active-high.
- Bus selects are one-hot every cycle. DOn is the idle select whenever no other driver is needed (reset, CLR cycle, halt, stalled or empty steps).
- Reset: RESET=1 at an edge forces state INIT, TSTATE=0, HALTED=0 and all outputs 0 except DOn=1. This applies mid-instruction too; there is no partial completion.
- INIT: the first cycle after RESET falls asserts CLR=1 for exactly one cycle. The next state is FETCH with TSTATE=0. CLR is never asserted otherwise.
- Advance condition: ADV = RUN | STEP.
  - When ADV=0, the state holds, all load strobes, CE and SU are 0, and the bus select is DOn.
  - Strobes are emitted only in cycles where ADV=1, so single-step executes exactly one T-state per STEP cycle.
- Fetch:
  - T0: COn, MIn.
  - T1: ROn, IIn, CE.
- Execute (T2..T4, by OPCODE):
  - 0x0 NOP: none.
  - 0x1 LDA: T2 IOn MIn; T3 ROn AIn.
  - 0x2 ADD: T2 IOn MIn; T3 ROn BIn; T4 EOn AIn FIn.
  - 0x3 SUB: as ADD, with SU=1 in T4.
  - 0x4 STA: T2 IOn MIn; T3 AOn RI.
  - 0x5 LDI: T2 IOn AIn.
  - 0x6 JMP: T2 IOn Jn.
  - 0x7 JC: T2 IOn Jn, only if CF=1.
  - 0x8 JZ: T2 IOn Jn, only if ZF=1.
  - 0x9 IN: T2 NOn AIn.
  - 0xE OUT: T2 AOn OIn.
  - 0xF HLT: T2 enters HALT.
  - 0xA-0xD: treated as NOP.
- Flag sampling: CF/ZF are sampled combinationally in T2 (the flags are already registered in the datapath).
- Step sequencing: TSTATE increments on each advancing edge and wraps to 0 after NSTEPS-1.
  - With EARLY_END=1, the wrap to 0 happens right after the last step carrying strobes: NOP and not-taken JC/JZ end after T2, not T1, so flag-sampling timing stays uniform.
- HALT: HALTED=1 and DOn-only outputs. HALT ignores RUN/STEP and is exited only by RESET.
- Simultaneous RESET and STEP: RESET wins.

Test Plan:
- Reset and clear: hold RESET 3 cycles, then release with RUN=1 -> CLR=1 on exactly the first cycle; next cycle TSTATE=0 with COn=1, MIn=1. While RESET is high, only DOn=1.
- ADD sequence: OPCODE=0x2, RUN=1, EARLY_END=1 -> T0 COn+MIn; T1 ROn+IIn+CE; T2 IOn+MIn; T3 ROn+BIn; T4 EOn+AIn+FIn with SU=0; next cycle TSTATE=0. Repeat with OPCODE=0x3 -> identical except SU=1 in T4.
- Conditional jumps: OPCODE=0x7 with CF=1 -> T2 IOn+Jn. With CF=0 -> T2 DOn only, then TSTATE=0. Repeat for 0x8 with ZF.
- Single-step: RUN=0, STEP pulsed 1 cycle every 4 cycles over an LDA -> TSTATE advances 0,1,2,3,0, one step per pulse. Between pulses, only DOn=1 and no CE/load strobe.
- HALT and reset mid-instruction: OPCODE=0xF -> HALTED=1 from the cycle after T2, held through 20 cycles of RUN=1/STEP=1. Separately, RESET during T3 of an ADD -> no AIn/FIn ever asserted; INIT/CLR sequence follows.
- One-hot sweep: random OPCODE/RUN/STEP/CF/ZF for 10k cycles -> exactly one bus select high every cycle; CLR never high outside INIT.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control interface between the sequencer (master) and the 8-bit datapath (slave).
interface control_sequencer_if;
  logic       RUN;
  logic       STEP;
  logic [3:0] OPCODE;
  logic       CF;
  logic       ZF;
  logic       CLR;
  logic       CE;
  logic       SU;
  logic       AIn, BIn, OIn, IIn, Jn, FIn, MIn, RI;
  logic       DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn;
  logic [2:0] TSTATE;
  logic       HALTED;

  modport master (
    input  RUN, STEP, OPCODE, CF, ZF,
    output CLR, CE, SU, AIn, BIn, OIn, IIn, Jn, FIn, MIn, RI,
    output DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn, TSTATE, HALTED
  );

  modport slave (
    output RUN, STEP, OPCODE, CF, ZF,
    input  CLR, CE, SU, AIn, BIn, OIn, IIn, Jn, FIn, MIn, RI,
    input  DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn, TSTATE, HALTED
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded fetch/execute sequencer: one T-state per advancing clock, run/single-step,
// halt state and a one-cycle datapath clear after reset.
module control_sequencer #(
  parameter int NSTEPS    = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  control_sequencer_if.master  bus
);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
  typedef enum logic [2:0] {
    SEL_D = 3'd0, SEL_A = 3'd1, SEL_B = 3'd2, SEL_I = 3'd3,
    SEL_C = 3'd4, SEL_E = 3'd5, SEL_R = 3'd6, SEL_N = 3'd7
  } sel_t;

  localparam logic [2:0] LAST_STEP = 3'(NSTEPS - 1);

  state_t     r_state;
  logic [2:0] r_tstate;
  logic [2:0] w_last;
  logic       w_adv;
  sel_t       w_sel;
  logic       w_clr, w_ce, w_su, w_ai, w_bi, w_oi, w_ii, w_j, w_fi, w_mi, w_ri;

  // Reset masks the advance so a reset cycle never emits a strobe.
  assign w_adv = (bus.RUN | bus.STEP) & ~RESET;

  // Index of the final T-state of the current instruction.
  always_comb begin
    w_last = LAST_STEP;
    if (EARLY_END) begin
      case (bus.OPCODE)
        4'h1, 4'h4: w_last = 3'd3;
        4'h2, 4'h3: w_last = 3'd4;
        default:    w_last = 3'd2;
      endcase
      if (w_last > LAST_STEP) w_last = LAST_STEP;
    end else begin
      w_last = LAST_STEP;
    end
  end

  // Sequencer state and step counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_INIT;
      r_tstate <= 3'd0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state  <= S_RUN;
          r_tstate <= 3'd0;
        end
        S_RUN: begin
          if (w_adv) begin
            if ((r_tstate == 3'd2) && (bus.OPCODE == 4'hF)) r_state <= S_HALT;
            else if (r_tstate >= w_last)                    r_tstate <= 3'd0;
            else                                            r_tstate <= r_tstate + 3'd1;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: begin
          r_state  <= S_INIT;
          r_tstate <= 3'd0;
        end
      endcase
    end
  end

  // Microcode decode of the current T-state into strobes and one bus driver.
  always_comb begin
    w_sel = SEL_D;
    {w_clr, w_ce, w_su, w_ai, w_bi, w_oi, w_ii, w_j, w_fi, w_mi, w_ri} = 11'd0;
    case (r_state)
      S_INIT: w_clr = ~RESET;
      S_RUN: begin
        if (w_adv) begin
          case (r_tstate)
            3'd0: begin w_sel = SEL_C; w_mi = 1'b1; end
            3'd1: begin w_sel = SEL_R; w_ii = 1'b1; w_ce = 1'b1; end
            3'd2: begin
              case (bus.OPCODE)
                4'h1, 4'h2, 4'h3, 4'h4: begin w_sel = SEL_I; w_mi = 1'b1; end
                4'h5: begin w_sel = SEL_I; w_ai = 1'b1; end
                4'h6: begin w_sel = SEL_I; w_j = 1'b1; end
                4'h7: if (bus.CF) begin w_sel = SEL_I; w_j = 1'b1; end else w_sel = SEL_D;
                4'h8: if (bus.ZF) begin w_sel = SEL_I; w_j = 1'b1; end else w_sel = SEL_D;
                4'h9: begin w_sel = SEL_N; w_ai = 1'b1; end
                4'hE: begin w_sel = SEL_A; w_oi = 1'b1; end
                default: w_sel = SEL_D;
              endcase
            end
            3'd3: begin
              case (bus.OPCODE)
                4'h1:       begin w_sel = SEL_R; w_ai = 1'b1; end
                4'h2, 4'h3: begin w_sel = SEL_R; w_bi = 1'b1; end
                4'h4:       begin w_sel = SEL_A; w_ri = 1'b1; end
                default:    w_sel = SEL_D;
              endcase
            end
            3'd4: begin
              if ((bus.OPCODE == 4'h2) || (bus.OPCODE == 4'h3)) begin
                w_sel = SEL_E;
                w_ai  = 1'b1;
                w_fi  = 1'b1;
                w_su  = (bus.OPCODE == 4'h3);
              end else begin
                w_sel = SEL_D;
              end
            end
            default: w_sel = SEL_D;
          endcase
        end else begin
          w_sel = SEL_D;
        end
      end
      S_HALT:  w_sel = SEL_D;
      default: w_sel = SEL_D;
    endcase
  end

  assign bus.CLR    = w_clr;
  assign bus.CE     = w_ce;
  assign bus.SU     = w_su;
  assign bus.AIn    = w_ai;
  assign bus.BIn    = w_bi;
  assign bus.OIn    = w_oi;
  assign bus.IIn    = w_ii;
  assign bus.Jn     = w_j;
  assign bus.FIn    = w_fi;
  assign bus.MIn    = w_mi;
  assign bus.RI     = w_ri;
  assign bus.DOn    = (w_sel == SEL_D);
  assign bus.AOn    = (w_sel == SEL_A);
  assign bus.BOn    = (w_sel == SEL_B);
  assign bus.IOn    = (w_sel == SEL_I);
  assign bus.COn    = (w_sel == SEL_C);
  assign bus.EOn    = (w_sel == SEL_E);
  assign bus.ROn    = (w_sel == SEL_R);
  assign bus.NOn    = (w_sel == SEL_N);
  assign bus.TSTATE = r_tstate;
  assign bus.HALTED = (r_state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: each instruction is expanded into its list of expected control words.
module tb_control_sequencer;

  localparam logic [19:0] M_CLR = 20'h00001, M_CE = 20'h00002, M_SU = 20'h00004;
  localparam logic [19:0] M_AI  = 20'h00008, M_BI = 20'h00010, M_OI = 20'h00020;
  localparam logic [19:0] M_II  = 20'h00040, M_J  = 20'h00080, M_FI = 20'h00100;
  localparam logic [19:0] M_MI  = 20'h00200, M_RI = 20'h00400, M_DO = 20'h00800;
  localparam logic [19:0] M_AO  = 20'h01000, M_BO = 20'h02000, M_IO = 20'h04000;
  localparam logic [19:0] M_CO  = 20'h08000, M_EO = 20'h10000, M_RO = 20'h20000;
  localparam logic [19:0] M_NO  = 20'h40000, M_H  = 20'h80000;
  localparam int MD_NONE = -1, MD_INIT = 0, MD_RUN = 1, MD_HALT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  control_sequencer_if bus();

  control_sequencer #(.NSTEPS(5), .EARLY_END(1'b1)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          mode = MD_NONE;
  int          idx = 0;
  bit          need_new = 1'b0;
  logic [3:0]  cur_op = 4'h0;
  logic        cur_cf = 1'b0, cur_zf = 1'b0;
  logic [19:0] prog[$];
  int          dq[$];   // directed instructions: op | cf<<4 | zf<<5

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic build(input logic [3:0] op, input logic cf, input logic zf);
    prog.delete();
    prog.push_back(M_CO | M_MI);
    prog.push_back(M_RO | M_II | M_CE);
    case (op)
      4'h1: begin prog.push_back(M_IO | M_MI); prog.push_back(M_RO | M_AI); end
      4'h2, 4'h3: begin
        prog.push_back(M_IO | M_MI);
        prog.push_back(M_RO | M_BI);
        prog.push_back(M_EO | M_AI | M_FI | ((op == 4'h3) ? M_SU : 20'h0));
      end
      4'h4: begin prog.push_back(M_IO | M_MI); prog.push_back(M_AO | M_RI); end
      4'h5: prog.push_back(M_IO | M_AI);
      4'h6: prog.push_back(M_IO | M_J);
      4'h7: prog.push_back(cf ? (M_IO | M_J) : M_DO);
      4'h8: prog.push_back(zf ? (M_IO | M_J) : M_DO);
      4'h9: prog.push_back(M_NO | M_AI);
      4'hE: prog.push_back(M_AO | M_OI);
      default: prog.push_back(M_DO);
    endcase
  endtask

  // One clock: pick the next instruction if due, check outputs at negedge, advance model.
  task automatic tick();
    logic [19:0] exp_w, obs_w;
    int          exp_t;
    bit          adv;
    int          d;
    if (need_new) begin
      if (dq.size() > 0) begin
        d = dq.pop_front();
        cur_op = 4'(d & 15); cur_cf = d[4]; cur_zf = d[5];
      end else begin
        cur_op = 4'($urandom_range(0, 14));
        cur_cf = 1'($urandom_range(0, 1));
        cur_zf = 1'($urandom_range(0, 1));
      end
      build(cur_op, cur_cf, cur_zf);
      need_new = 1'b0;
    end
    bus.OPCODE = cur_op; bus.CF = cur_cf; bus.ZF = cur_zf;
    @(negedge clk);
    adv = (bus.RUN || bus.STEP) && !rst;
    exp_t = -1;
    exp_w = M_DO;
    case (mode)
      MD_INIT: begin exp_w = rst ? M_DO : (M_DO | M_CLR); exp_t = 0; end
      MD_RUN:  begin exp_w = adv ? prog[idx] : M_DO; exp_t = idx; end
      MD_HALT: exp_w = M_DO | M_H;
      default: exp_w = M_DO;
    endcase
    obs_w = {bus.HALTED, bus.NOn, bus.ROn, bus.EOn, bus.COn, bus.IOn, bus.BOn, bus.AOn,
             bus.DOn, bus.RI, bus.MIn, bus.FIn, bus.Jn, bus.IIn, bus.OIn, bus.BIn, bus.AIn,
             bus.SU, bus.CE, bus.CLR};
    if (mode != MD_NONE) begin
      chk("ctrl", 32'(obs_w), 32'(exp_w));
      chk("onehot", $countones(obs_w[18:11]), 32'd1);
      if (exp_t >= 0) chk("tstate", 32'(bus.TSTATE), exp_t);
    end
    @(posedge clk);
    if (rst) begin
      mode = MD_INIT; need_new = 1'b0;
    end else begin
      case (mode)
        MD_INIT: begin mode = MD_RUN; idx = 0; need_new = 1'b1; end
        MD_RUN: if (adv) begin
          if ((cur_op == 4'hF) && (idx == 2)) mode = MD_HALT;
          else begin
            idx++;
            if (idx == prog.size()) begin idx = 0; need_new = 1'b1; end
          end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  initial begin
    int cnt;
    bit hit;
    bus.RUN = 1'b1; bus.STEP = 1'b0; bus.OPCODE = 4'h0; bus.CF = 1'b0; bus.ZF = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Directed run-mode program: arithmetic, both jump outcomes, every other opcode.
    dq = '{2, 3, 7 | 16, 7, 8 | 32, 8, 1, 4, 5, 6, 9, 14, 0, 10, 13};
    cnt = 0;
    while ((dq.size() > 0 || !need_new) && cnt < 200) begin tick(); cnt++; end
    chk("directed_bound", 32'(cnt < 200), 32'd1);

    // Single-step two LDAs: one step pulse every 4 cycles.
    dq = '{1, 1};
    bus.RUN = 1'b0;
    for (int k = 0; k < 32; k++) begin
      bus.STEP = (k % 4 == 0);
      tick();
    end
    bus.STEP = 1'b0;

    // Random sweep with occasional mid-instruction resets (HLT excluded here).
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      bus.RUN  = 1'($urandom_range(0, 1));
      bus.STEP = 1'($urandom_range(0, 1));
      tick();
    end

    // HLT, then 20 cycles of RUN/STEP which must not leave HALT.
    rst = 1'b1; bus.RUN = 1'b1; bus.STEP = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    dq = '{15};
    cnt = 0;
    while (mode != MD_HALT && cnt < 30) begin tick(); cnt++; end
    chk("halt_bound", 32'(cnt < 30), 32'd1);
    bus.STEP = 1'b1;
    repeat (20) tick();
    chk("halt_held", 32'(bus.HALTED), 32'd1);

    // Reset arriving during T3 of an ADD.
    rst = 1'b1; bus.STEP = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    dq = '{2};
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      if (mode == MD_RUN && !need_new && cur_op == 4'h2 && idx == 3) begin
        rst = 1'b1; hit = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    chk("mid_reset_bound", 32'(hit), 32'd1);
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
